// File: rtl/clock_gen_pkg.sv
// Shared types and config legalisation for the multi-channel clock generator.
package clock_gen_pkg;

  // Config fields are carried at this fixed width; DIV_WIDTH must not exceed it.
  localparam int MAX_DIV_W = 32;

  typedef enum logic {
    CLK_LOW  = 1'b0,
    CLK_HIGH = 1'b1
  } CLOCK_ENUM;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  typedef struct packed {
    logic [MAX_DIV_W-1:0] period;
    logic [MAX_DIV_W-1:0] high;
  } cfg_t;

  // Forces period >= 2 and 1 <= high < period so a running channel always toggles.
  function automatic cfg_t legalise(input cfg_t raw);
    cfg_t res;
    res.period = (raw.period < MAX_DIV_W'(2)) ? MAX_DIV_W'(2) : raw.period;
    if (raw.high >= res.period) begin
      res.high = res.period - MAX_DIV_W'(1);
    end else if (raw.high == '0) begin
      res.high = MAX_DIV_W'(1);
    end else begin
      res.high = raw.high;
    end
    return res;
  endfunction

endpackage

// File: rtl/clock_gen_channel.sv
// One divided-clock channel: period counter, IDLE/RUN FSM, shadow config slot
// and registered rising/falling tick strobes.
module clock_gen_channel
  import clock_gen_pkg::*;
#(
  parameter int DIV_WIDTH      = 16,
  parameter int DEFAULT_PERIOD = 833,
  parameter int DEFAULT_HIGH   = 416
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 sync_i,
  input  logic                 accept_i,
  input  logic [DIV_WIDTH-1:0] period_i,
  input  logic [DIV_WIDTH-1:0] high_i,
  output logic                 pending_o,
  output logic                 clk_o,
  output logic                 rise_o,
  output logic                 fall_o
);

  ch_state_e            state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  CLOCK_ENUM            clk_q, clk_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  cfg_t                 act_q, act_d;
  cfg_t                 shd_q, shd_d;
  logic                 pend_q, pend_d;

  cfg_t                 use_cfg;
  logic [DIV_WIDTH-1:0] cnt_inc;
  logic                 wrap;

  // Pending shadow values take effect on the same edge they are copied.
  assign use_cfg = pend_q ? shd_q : act_q;
  assign cnt_inc = cnt_q + DIV_WIDTH'(1);
  assign wrap    = (MAX_DIV_W'(cnt_q) == (act_q.period - MAX_DIV_W'(1)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    act_d   = act_q;
    shd_d   = shd_q;
    pend_d  = pend_q;

    case (state_q)
      CH_IDLE: begin
        cnt_d  = '0;
        clk_d  = CLK_LOW;
        act_d  = use_cfg;
        pend_d = 1'b0;
        if (enable_i) begin
          state_d = CH_RUN;
          clk_d   = (use_cfg.high != '0) ? CLK_HIGH : CLK_LOW;
        end
      end
      CH_RUN: begin
        if (!enable_i) begin
          state_d = CH_IDLE;
          cnt_d   = '0;
          clk_d   = CLK_LOW;
        end else if (sync_i || wrap) begin
          act_d  = use_cfg;
          pend_d = 1'b0;
          cnt_d  = '0;
          clk_d  = (use_cfg.high != '0) ? CLK_HIGH : CLK_LOW;
        end else begin
          cnt_d = cnt_inc;
          clk_d = (MAX_DIV_W'(cnt_inc) < act_q.high) ? CLK_HIGH : CLK_LOW;
        end
      end
    endcase

    // Accept only happens with the slot empty, so it never collides with a copy.
    if (accept_i) begin
      shd_d  = legalise('{period: MAX_DIV_W'(period_i), high: MAX_DIV_W'(high_i)});
      pend_d = 1'b1;
    end

    rise_d = (clk_d == CLK_HIGH) && (clk_q == CLK_LOW);
    fall_d = (clk_d == CLK_LOW) && (clk_q == CLK_HIGH);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      clk_q   <= CLK_LOW;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      act_q   <= '{period: MAX_DIV_W'(DEFAULT_PERIOD), high: MAX_DIV_W'(DEFAULT_HIGH)};
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
    end
  end

  // Shadow contents are qualified by pend_q and need no reset.
  always_ff @(posedge clk_i) begin
    shd_q <= shd_d;
  end

  assign pending_o = pend_q;
  assign clk_o     = (clk_q == CLK_HIGH);
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;

endmodule

// File: rtl/multi_clock_generator.sv
// NUM_CHANNELS programmable clock dividers sharing one valid/ready config port.
module multi_clock_generator
  import clock_gen_pkg::*;
#(
  parameter int NUM_CHANNELS   = 2,
  parameter int DIV_WIDTH      = 16,
  parameter int DEFAULT_PERIOD = 833,
  parameter int DEFAULT_HIGH   = 416,
  localparam int CH_W          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    inputClock,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] enable,
  input  logic                    syncStart,
  input  logic                    cfgValid,
  output logic                    cfgReady,
  input  logic [CH_W-1:0]         cfgChannel,
  input  logic [DIV_WIDTH-1:0]    cfgPeriod,
  input  logic [DIV_WIDTH-1:0]    cfgHigh,
  output logic [NUM_CHANNELS-1:0] outputClock,
  output logic [NUM_CHANNELS-1:0] risingTick,
  output logic [NUM_CHANNELS-1:0] fallingTick
);

  logic [NUM_CHANNELS-1:0] pending;
  logic [NUM_CHANNELS-1:0] accept;

  // Out-of-range channel numbers are never ready, so they can't be accepted.
  always_comb begin
    cfgReady = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (cfgChannel == CH_W'(i)) begin
        cfgReady = ~pending[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    assign accept[g] = cfgValid && cfgReady && (cfgChannel == CH_W'(g));

    clock_gen_channel #(
      .DIV_WIDTH     (DIV_WIDTH),
      .DEFAULT_PERIOD(DEFAULT_PERIOD),
      .DEFAULT_HIGH  (DEFAULT_HIGH)
    ) u_ch (
      .clk_i    (inputClock),
      .rst_i    (reset),
      .enable_i (enable[g]),
      .sync_i   (syncStart),
      .accept_i (accept[g]),
      .period_i (cfgPeriod),
      .high_i   (cfgHigh),
      .pending_o(pending[g]),
      .clk_o    (outputClock[g]),
      .rise_o   (risingTick[g]),
      .fall_o   (fallingTick[g])
    );
  end

endmodule

// File: tb/tb_multi_clock_generator.sv
// Directed bench for multi_clock_generator: a phase-based reference model is
// compared every cycle, and literal waveform measurements pin the model.
module tb_multi_clock_generator;

  localparam int N  = 2;
  localparam int W  = 16;
  localparam int DP = 833;
  localparam int DH = 416;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] en = '0;
  logic         sync = 1'b0;
  logic         cv = 1'b0;
  logic         cr;
  logic         cch = 1'b0;
  logic [W-1:0] cp = '0;
  logic [W-1:0] chh = '0;
  logic [N-1:0] oc, rt, ft;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_clock_generator #(
    .NUM_CHANNELS  (N),
    .DIV_WIDTH     (W),
    .DEFAULT_PERIOD(DP),
    .DEFAULT_HIGH  (DH)
  ) dut (
    .inputClock (clk),
    .reset      (rst),
    .enable     (en),
    .syncStart  (sync),
    .cfgValid   (cv),
    .cfgReady   (cr),
    .cfgChannel (cch),
    .cfgPeriod  (cp),
    .cfgHigh    (chh),
    .outputClock(oc),
    .risingTick (rt),
    .fallingTick(ft)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: each running channel is a phase position within its period;
  // the clock is high while phase < high.
  bit m_run[N];
  int m_ph[N], m_per[N], m_hi[N], m_sp[N], m_sh[N];
  bit m_pend[N], m_out[N], m_rt[N], m_ft[N];

  task automatic model_step();
    bit acc[N];
    bit prev;
    int p, h;
    for (int c = 0; c < N; c++) acc[c] = cv && (int'(cch) == c) && !m_pend[c];
    for (int c = 0; c < N; c++) begin
      if (rst) begin
        m_run[c] = 0; m_ph[c] = 0; m_per[c] = DP; m_hi[c] = DH;
        m_pend[c] = 0; m_out[c] = 0; m_rt[c] = 0; m_ft[c] = 0;
      end else begin
        prev = m_out[c];
        if (!m_run[c]) begin
          if (m_pend[c]) begin m_per[c] = m_sp[c]; m_hi[c] = m_sh[c]; m_pend[c] = 0; end
          if (en[c]) begin m_run[c] = 1; m_ph[c] = 0; end
        end else if (!en[c]) begin
          m_run[c] = 0; m_ph[c] = 0;
        end else if (sync || m_ph[c] == m_per[c] - 1) begin
          if (m_pend[c]) begin m_per[c] = m_sp[c]; m_hi[c] = m_sh[c]; m_pend[c] = 0; end
          m_ph[c] = 0;
        end else begin
          m_ph[c] = m_ph[c] + 1;
        end
        m_out[c] = m_run[c] && (m_ph[c] < m_hi[c]);
        m_rt[c]  = m_out[c] && !prev;
        m_ft[c]  = !m_out[c] && prev;
        if (acc[c]) begin
          p = (int'(cp) < 2) ? 2 : int'(cp);
          h = (int'(chh) >= p) ? p - 1 : ((chh == 0) ? 1 : int'(chh));
          m_sp[c] = p; m_sh[c] = h; m_pend[c] = 1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    for (int c = 0; c < N; c++) begin
      check($sformatf("model_clk%0d", c), oc[c], m_out[c]);
      check($sformatf("model_rise%0d", c), rt[c], m_rt[c]);
      check($sformatf("model_fall%0d", c), ft[c], m_ft[c]);
    end
    check("model_ready", cr, !m_pend[cch]);
  end

  task automatic wait_rise(input int ch, input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (rt[ch] !== 1'b1 && cycles < limit);
  endtask

  initial begin
    int g, h, r, f, c1, both, r0, r1;

    repeat (3) @(negedge clk);
    check("rst_clk", oc, 0);
    check("rst_rise", rt, 0);
    check("rst_fall", ft, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cr, 1);
    check("idle_clk", oc, 0);

    // Defaults on channel 0.
    en = 2'b01;
    wait_rise(0, 5, g);
    check("t1_first_rise_latency", g, 1);
    h = 0; r = 0; c1 = 0;
    for (int k = 0; k < DP; k++) begin
      h += int'(oc[0]); r += int'(rt[0]); c1 += int'(oc[1]);
      @(negedge clk);
    end
    check("t1_high_cycles", h, 416);
    check("t1_rises_per_period", r, 1);
    check("t1_ch1_quiet", c1, 0);
    check("t1_rise_after_833", rt[0], 1);

    // Mid-period reconfig of channel 0.
    repeat (100) @(negedge clk);
    cv = 1'b1; cch = 1'b0; cp = 16'd10; chh = 16'd3;
    check("t2_ready_before", cr, 1);
    @(negedge clk);
    cv = 1'b0;
    check("t2_ready_dropped", cr, 0);
    wait_rise(0, 1000, g);
    check("t2_cycles_to_wrap", g, 732);
    check("t2_ready_back", cr, 1);
    h = 0; r = 0;
    for (int k = 0; k < 10; k++) begin
      h += int'(oc[0]); r += int'(rt[0]);
      @(negedge clk);
    end
    check("t2_high_cycles", h, 3);
    check("t2_rises", r, 1);
    check("t2_rise_after_10", rt[0], 1);

    // Illegal config on idle channel 1 legalises to 2/1.
    cv = 1'b1; cch = 1'b1; cp = 16'd1; chh = 16'd5;
    check("t3_ready_before", cr, 1);
    @(negedge clk);
    cv = 1'b0;
    check("t3_ready_stall", cr, 0);
    @(negedge clk);
    check("t3_ready_idle_copy", cr, 1);
    en = 2'b11;
    h = 0; r = 0; f = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      h += int'(oc[1]); r += int'(rt[1]); f += int'(ft[1]);
    end
    check("t3_high_cycles", h, 3);
    check("t3_rises", r, 3);
    check("t3_falls", f, 3);

    // Phase-aligned start of 10- and 7-cycle channels.
    cv = 1'b1; cch = 1'b1; cp = 16'd7; chh = 16'd3;
    @(negedge clk);
    cv = 1'b0;
    repeat (4) @(negedge clk);
    en = 2'b00;
    repeat (2) @(negedge clk);
    en = 2'b11; sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    check("t4_both_rise", rt, 2'b11);
    check("t4_both_high", oc, 2'b11);
    both = 0; r0 = 0; r1 = 0;
    for (int k = 0; k < 70; k++) begin
      both += int'(rt == 2'b11); r0 += int'(rt[0]); r1 += int'(rt[1]);
      @(negedge clk);
    end
    check("t4_coincident", both, 1);
    check("t4_ch0_rises", r0, 7);
    check("t4_ch1_rises", r1, 10);
    check("t4_realign_70", rt, 2'b11);
    @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    check("t4_sync_high_no_tick", rt, 0);
    check("t4_sync_high_stays", oc, 2'b11);

    // Reset mid-high with a pending update.
    cv = 1'b1; cch = 1'b0; cp = 16'd20; chh = 16'd5;
    @(negedge clk);
    cv = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_clk", oc, 0);
    check("t5_rst_rise", rt, 0);
    check("t5_rst_fall", ft, 0);
    check("t5_rst_ready", cr, 1);
    rst = 1'b0;
    wait_rise(0, 5, g);
    check("t5_restart_latency", g, 1);
    wait_rise(0, 2000, g);
    check("t5_default_period", g, 833);

    // Disable while high, then re-enable.
    en = 2'b10;
    @(negedge clk);
    check("t6_disable_clk", oc[0], 0);
    check("t6_disable_fall", ft[0], 1);
    en = 2'b11;
    @(negedge clk);
    check("t6_reenable_clk", oc[0], 1);
    check("t6_reenable_rise", rt[0], 1);
    wait_rise(0, 2000, g);
    check("t6_period", g, 833);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_clock_generator.md
Name: multi_clock_generator

Overview:
Parametrised successor to the single fixed-ratio clock divider. Generates NUM_CHANNELS independent divided clocks from one input clock. Each channel has a run-time programmable period and high time, set through a valid/ready configuration port. Updates apply glitch-free at period boundaries, and each channel emits single-cycle rising/falling tick strobes for use as clock enables by downstream I2C/UART timing logic.

Parameters:
NUM_CHANNELS, 2, number of independent output channels (>=1)
DIV_WIDTH, 16, width of period/high-time counters and config fields
DEFAULT_PERIOD, 833, reset period in input cycles (>=2, < 2**DIV_WIDTH)
DEFAULT_HIGH, 416, reset high time in input cycles

Ports:
inputClock  in  1  primary input clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
enable  in  NUM_CHANNELS  per-channel run enable, level
syncStart  in  1  one-cycle pulse; restarts all enabled channels phase-aligned
cfgValid  in  1  config write request
cfgReady  out  1  config write accepted when cfgValid && cfgReady
cfgChannel  in  $clog2(NUM_CHANNELS) (min 1)  target channel
cfgPeriod  in  DIV_WIDTH  new period in input cycles
cfgHigh  in  DIV_WIDTH  new high time in input cycles
outputClock  out  NUM_CHANNELS  divided clocks, registered
risingTick  out  NUM_CHANNELS  1-cycle pulse, registered with a 0->1 of outputClock
fallingTick  out  NUM_CHANNELS  1-cycle pulse, registered with a 1->0 of outputClock

Behaviour:
- Reset (sync, active-high; dominates everything, including mid-period): outputClock=0, ticks=0, counters=0, all channels IDLE, active period/high = DEFAULT_PERIOD/DEFAULT_HIGH, no pending config. cfgReady=1 in the cycle after reset deasserts.
- Per-channel FSM, IDLE and RUN:
  - IDLE: counter=0, outputClock=0. If enable=1 at an edge: go to RUN, counter<=0, outputClock<=(high>0), risingTick<=(high>0).
  - RUN: each edge, counter<=(counter==period-1)?0:counter+1. outputClock<=(next counter<high). Ticks mark the transitions.
  - RUN to IDLE on enable=0 at an edge: outputClock<=0, counter<=0. fallingTick pulses if the output was high.
- Waveform: high for exactly `high` cycles, then low for period-`high` cycles. Repeats with exactly `period` cycles between risingTicks.
- Legalisation, applied when config is latched:
  - period<2 is stored as 2.
  - high>=period is stored as period-1.
  - high=0 is stored as 1.
  - Every running channel therefore toggles.
- Config handshake:
  - Each channel holds one shadow (pending) slot.
  - cfgReady = ~pending[cfgChannel] (combinational on cfgChannel).
  - On accept, the legalised values go into shadow and pending<=1.
  - In RUN, shadow is copied to active on the edge where counter wraps period-1->0. The new values govern that cycle's outputClock; pending clears.
  - In IDLE, shadow is copied to active on the next edge.
  - A write to a pending channel stalls (cfgReady=0) until the copy. Writes to other channels are unaffected.
- syncStart=1 at an edge:
  - Every channel with enable=1 restarts at counter 0, outputClock<=1, and applies any pending config first.
  - Channels already at counter 0 therefore show no glitch. A channel that was high stays high with no tick.
  - syncStart with enable rising in the same cycle behaves identically to a plain enable rise.
- Simultaneous accept and wrap on the same channel: cannot occur (cfgReady=0 while pending). An accept into an empty slot on a wrap cycle applies at the next wrap.
- Widths: counters DIV_WIDTH bits, no overflow because period<2**DIV_WIDTH. Comparisons are unsigned.

Decomposition:
- Package clock_gen_pkg: CLOCK_ENUM (CLK_LOW/CLK_HIGH), the channel state enum (CH_IDLE/CH_RUN), a cfg struct {period, high}, and the legalise function.
- One sub-module, clock_gen_channel (counter, FSM, shadow slot, ticks). It is instantiated NUM_CHANNELS times by a generate loop.
- The top holds only cfgChannel decode and the cfgReady mux.

Test Plan:
1. Reset, then enable[0]=1 with defaults -> outputClock[0] high 416 cycles, low 417, risingTick every 833 cycles; channel 1 stays 0.
2. Write ch0 period=10, high=3 mid-period -> cfgReady drops next cycle; old waveform completes; from the wrap edge, 3 high/7 low; cfgReady returns at the wrap.
3. Write ch1 period=1, high=5 -> stored 2/1; output toggles every cycle with alternating rising/falling ticks.
4. ch0 period=10, ch1 period=7, both enabled, pulse syncStart -> both outputs and risingTicks assert on the same edge; repeats every 70 cycles.
5. Assert reset mid-high-phase -> outputClock=0, ticks=0 next edge; after release, period reverts to 833 and no pending update is applied.
6. Deassert enable[0] while high -> outputClock 0 and fallingTick pulses on the same edge; re-enable -> rising edge immediately with counter 0.
